// File: rtl/branch_resolve_stage.sv
// EX/MEM branch resolution stage for the pipelined MIPS core.
// Registers the ALU compare flags (as four per-type condition bits), the
// branch type and the target. Produces taken / pc_src and a one-shot flush
// request toward IF and the hazard unit.
// Optional build macro: BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_resolve_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              branch_i,
  input  logic [1:0]        br_type_i,
  input  logic              zero_i,
  input  logic              sign_i,
  input  logic              ovf_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              valid_o,
  output logic [3:0]        cond_o,
  output logic [1:0]        select_o,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              pc_src_o,
  output logic              flush_req_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o
`endif
);

  logic              valid_q;
  logic              branch_q;
  logic [3:0]        cond_q;
  logic [1:0]        select_q;
  logic [ADDR_W-1:0] target_q;
  logic              req_done;
  logic              lt;
  logic [3:0]        cond_d;

  // A zero-width counter configuration is meaningless.
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  // Signed less-than from rs-rt flags, expanded to {bne,bgt,bge,beq}.
  always_comb begin
    lt     = sign_i ^ ovf_i;
    cond_d = '0;
    cond_d[0] = zero_i;
    cond_d[1] = ~lt;
    cond_d[2] = ~lt & ~zero_i;
    cond_d[3] = ~zero_i;
  end

  // Stage register: flush beats stall beats load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      cond_q   <= '0;
      select_q <= '0;
      target_q <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      cond_q   <= '0;
      select_q <= '0;
      target_q <= '0;
    end else if (!stall_i) begin
      valid_q  <= valid_i;
      branch_q <= branch_i;
      cond_q   <= cond_d;
      select_q <= br_type_i;
      target_q <= target_i;
    end
  end

  // Remember that the flush request was already issued while the branch is
  // held by a stall, so a multi-cycle stall yields a single request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_done <= 1'b0;
    end else if (flush_i) begin
      req_done <= 1'b0;
    end else if (stall_i) begin
      if (flush_req_o) begin
        req_done <= 1'b1;
      end
    end else begin
      req_done <= 1'b0;
    end
  end

  // Resolution outputs derived from the registered occupant.
  always_comb begin
    valid_o     = valid_q;
    cond_o      = cond_q;
    select_o    = select_q;
    target_o    = target_q;
    taken_o     = valid_q & branch_q & cond_q[select_q];
    pc_src_o    = taken_o;
    flush_req_o = taken_o & ~req_done;
  end

`ifdef BRANCH_STATS_EN
  // Count branches as they retire from the stage; squashed ones are skipped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_o    <= '0;
      taken_cnt_o <= '0;
    end else if (valid_q && branch_q && !stall_i && !flush_i) begin
      if (br_cnt_o != '1) begin
        br_cnt_o <= br_cnt_o + CNT_W'(1);
      end
      if (taken_o && (taken_cnt_o != '1)) begin
        taken_cnt_o <= taken_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule
